// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss fill controller: fetches the 8-word block containing PC, then pulses update.
// Optional performance counters are built when ICACHE_FILL_PERF_EN is defined.
module icache_fill_ctrl #(
  parameter int MEM_ADDR_WIDTH = 32
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [31:0]               PC,
  input  logic                      miss,
  output logic                      stall,
  output logic                      mem_rden,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]               mem_rdata,
  input  logic                      mem_valid,
  output logic [31:0]               w0,
  output logic [31:0]               w1,
  output logic [31:0]               w2,
  output logic [31:0]               w3,
  output logic [31:0]               w4,
  output logic [31:0]               w5,
  output logic [31:0]               w6,
  output logic [31:0]               w7,
  output logic                      update
`ifdef ICACHE_FILL_PERF_EN
  ,
  output logic [31:0]               perf_misses,
  output logic [31:0]               perf_fill_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [26:0] blk_q, blk_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] w_q [8];
  logic [31:0] w_d [8];

  // Offset bits within the block never affect the fill.
  logic unused_pc_bits;
  assign unused_pc_bits = ^PC[4:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      for (int i = 0; i < 8; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      for (int i = 0; i < 8; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  // The read address is loaded on entry to REQ so it is stable for the strobe and held afterwards.
  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    w_d        = w_q;
    mem_rden   = 1'b0;
    update     = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss) begin
          blk_d      = PC[31:5];
          cnt_d      = 3'd0;
          mem_addr_d = {PC[31:5], 5'b00000};
          state_d    = REQ;
        end
      end
      REQ: begin
        mem_rden = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (mem_valid) begin
          w_d[cnt_q] = mem_rdata;
          if (cnt_q == 3'd7) begin
            state_d = UPDATE;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            mem_addr_d = {blk_q, cnt_q + 3'd1, 2'b00};
            state_d    = REQ;
          end
        end
      end
      UPDATE: begin
        update  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall    = (state_q != IDLE) | miss;
  assign mem_addr = MEM_ADDR_WIDTH'(mem_addr_q);
  assign w0 = w_q[0];
  assign w1 = w_q[1];
  assign w2 = w_q[2];
  assign w3 = w_q[3];
  assign w4 = w_q[4];
  assign w5 = w_q[5];
  assign w6 = w_q[6];
  assign w7 = w_q[7];

`ifdef ICACHE_FILL_PERF_EN
  logic [31:0] perf_misses_q, perf_misses_d;
  logic [31:0] perf_fill_cycles_q, perf_fill_cycles_d;

  // Both counters stop at all-ones instead of wrapping.
  always_comb begin
    perf_misses_d      = perf_misses_q;
    perf_fill_cycles_d = perf_fill_cycles_q;
    if ((state_q == IDLE) && miss && (perf_misses_q != 32'hFFFF_FFFF)) begin
      perf_misses_d = perf_misses_q + 32'd1;
    end
    if ((state_q != IDLE) && (perf_fill_cycles_q != 32'hFFFF_FFFF)) begin
      perf_fill_cycles_d = perf_fill_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_misses_q      <= '0;
      perf_fill_cycles_q <= '0;
    end else begin
      perf_misses_q      <= perf_misses_d;
      perf_fill_cycles_q <= perf_fill_cycles_d;
    end
  end

  assign perf_misses      = perf_misses_q;
  assign perf_fill_cycles = perf_fill_cycles_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: drives the memory handshake by hand and checks each cycle.
module tb_icache_fill_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] PC = '0;
  logic        miss = 1'b0;
  logic        stall;
  logic        mem_rden;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_valid = 1'b0;
  logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
  logic        update;
`ifdef ICACHE_FILL_PERF_EN
  logic [31:0] perf_misses;
  logic [31:0] perf_fill_cycles;
`endif

  int checks = 0;
  int failures = 0;

  icache_fill_ctrl #(.MEM_ADDR_WIDTH(32)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .PC        (PC),
    .miss      (miss),
    .stall     (stall),
    .mem_rden  (mem_rden),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .w0        (w0),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .w4        (w4),
    .w5        (w5),
    .w6        (w6),
    .w7        (w7),
    .update    (update)
`ifdef ICACHE_FILL_PERF_EN
    ,
    .perf_misses      (perf_misses),
    .perf_fill_cycles (perf_fill_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  function automatic logic [31:0] wsel(input int k);
    case (k)
      0: return w0;
      1: return w1;
      2: return w2;
      3: return w3;
      4: return w4;
      5: return w5;
      6: return w6;
      default: return w7;
    endcase
  endfunction

  function automatic logic [31:0] word_data(input logic [31:0] pc, input int k);
    logic [2:0] idx;
    idx = k[2:0];
    return {pc[31:5], idx, 2'b00} ^ 32'hA5A5_0000;
  endfunction

  // Called at the falling edge of an IDLE cycle; returns at the falling edge of the UPDATE cycle
  // (or right after asserting reset in the first WAIT cycle of word rst_word).
  task automatic run_fill(input logic [31:0] pc, input bit alt_lat, input bit inject,
                          input logic [31:0] prev_pc, input int chg_word,
                          input logic [31:0] new_pc, input int rst_word, input int exp_upd);
    int cyc;
    int lat;
    logic [2:0] idx;
    logic [31:0] a;
    PC   = pc;
    miss = 1'b1;
    cyc  = 0;
    #1;
    check("idle_rden", 32'(mem_rden), 32'd0);
    check("idle_update", 32'(update), 32'd0);
    check("miss_stall", 32'(stall), 32'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      cyc++;
      mem_valid = 1'b0;
      idx = k[2:0];
      a = {pc[31:5], idx, 2'b00};
      #1;
      check("req_rden", 32'(mem_rden), 32'd1);
      check("req_addr", mem_addr, a);
      check("req_stall", 32'(stall), 32'd1);
      if (inject) begin
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
      lat = (alt_lat && k[0]) ? 3 : 1;
      for (int j = 1; j <= lat; j++) begin
        step();
        cyc++;
        mem_valid = 1'b0;
        #1;
        check("wait_rden", 32'(mem_rden), 32'd0);
        check("wait_stall", 32'(stall), 32'd1);
        if (inject && j == 1) begin
          check("req_valid_dropped", wsel(k), word_data(prev_pc, k));
        end
        if (k == rst_word) begin
          RST_N = 1'b0;
          #1;
          check("rst_rden", 32'(mem_rden), 32'd0);
          check("rst_update", 32'(update), 32'd0);
          check("rst_addr", mem_addr, 32'd0);
          check("rst_w0", w0, 32'd0);
          check("rst_w4", w4, 32'd0);
          check("rst_stall_follows_miss", 32'(stall), 32'd1);
          return;
        end
        if (j == lat) begin
          mem_valid = 1'b1;
          mem_rdata = a ^ 32'hA5A5_0000;
        end
      end
      if (k == chg_word) begin
        PC = new_pc;
      end
    end
    step();
    cyc++;
    mem_valid = 1'b0;
    #1;
    check("update", 32'(update), 32'd1);
    check("update_cycle", cyc, exp_upd);
    check("update_stall", 32'(stall), 32'd1);
    check("update_rden", 32'(mem_rden), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("w%0d", k), wsel(k), word_data(pc, k));
    end
    $display("fill pc=%h done at cycle %0d", pc, cyc);
  endtask

  // Falling edge of the IDLE cycle after UPDATE: cache has written, miss drops.
  task automatic finish_fill();
    step();
    miss = 1'b0;
    #1;
    check("post_update", 32'(update), 32'd0);
    check("hit_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_rden", 32'(mem_rden), 32'd0);
    check("reset_update", 32'(update), 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_w7", w7, 32'd0);
    step();
    RST_N = 1'b1;
    step();

    // Single fill, L=1
    run_fill(32'h0000_0124, 1'b0, 1'b0, 32'h0, -1, 32'h0, -1, 17);
    finish_fill();
    check("w0_holds", w0, 32'hA5A5_0120);
    check("w7_holds", w7, 32'hA5A5_013C);

    // Variable latency 1,3 with protocol-error valid during every REQ
    step();
    run_fill(32'h0000_1000, 1'b1, 1'b1, 32'h0000_0124, -1, 32'h0, -1, 25);
    finish_fill();

    // PC change mid-fill, then reset during word 5
    step();
    run_fill(32'h0000_0124, 1'b0, 1'b0, 32'h0, 1, 32'h0000_0400, 5, 0);
    step();
    #1;
    check("in_reset_rden", 32'(mem_rden), 32'd0);
    check("in_reset_update", 32'(update), 32'd0);
    RST_N = 1'b1;
    run_fill(32'h0000_0400, 1'b0, 1'b0, 32'h0, -1, 32'h0, -1, 17);
    finish_fill();

    // Back-to-back misses with a single IDLE cycle between fills
    step();
    run_fill(32'h0000_0000, 1'b0, 1'b0, 32'h0, -1, 32'h0, -1, 17);
    step();
    run_fill(32'h0000_0020, 1'b0, 1'b0, 32'h0, -1, 32'h0, -1, 17);
    finish_fill();

`ifdef ICACHE_FILL_PERF_EN
    step();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    #1;
    check("perf_misses_reset", perf_misses, 32'd0);
    check("perf_cycles_reset", perf_fill_cycles, 32'd0);
    for (int f = 0; f < 3; f++) begin
      step();
      run_fill(32'h0000_0200, 1'b0, 1'b0, 32'h0, -1, 32'h0, -1, 17);
      finish_fill();
    end
    check("perf_misses_3", perf_misses, 32'd3);
    check("perf_cycles_51", perf_fill_cycles, 32'd51);
    step();
    force dut.perf_misses_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_misses_q;
    run_fill(32'h0000_0200, 1'b0, 1'b0, 32'h0, -1, 32'h0, -1, 17);
    finish_fill();
    check("perf_misses_sat", perf_misses, 32'hFFFF_FFFF);
    check("perf_cycles_68", perf_fill_cycles, 32'd68);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
